// File: rtl/ldl_ram_p1_be.sv
// ldl_ram_p1_be -- single-port synchronous RAM with byte-lane write enables,
// selectable read-during-write behaviour, optional output register and a
// clear sequencer that sweeps INIT_VAL into every word after reset or on clr.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (forces a fresh clear sweep)
//   clr     request a full-memory clear, honoured only when idle
//   busy    high while the clear sweep runs; re/we/clr ignored meanwhile
//   re, we  read / write enables (shared address)
//   be      byte-lane write enables, lane i = din[i*BWIDTH +: BWIDTH]
//   addr    word address
//   din     write data
//   dout    read data, held between reads
//   dvalid  one-cycle pulse for each new word on dout
//
// Storage is split into one sub-module per byte lane; each lane owns its own
// memory and first-stage read register so lane writes stay independent.

module ldl_ram_p1_be_lane #(
    parameter int AWIDTH  = 6,
    parameter int BWIDTH  = 8,
    parameter int RD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic [AWIDTH-1:0] addr,
    input  logic [BWIDTH-1:0] wdata,
    output logic [BWIDTH-1:0] rdata
);
    // No reset on the array: contents are defined by the clear sweep.
    logic [BWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (wen) mem[addr] <= wdata;
    end

    // Write-first bypasses the freshly written lane; unwritten lanes
    // (wen low) always return the stored value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rdata <= '0;
        else if (ren) rdata <= (RD_MODE == 1 && wen) ? wdata : mem[addr];
    end
endmodule

module ldl_ram_p1_be #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 6,
    parameter int                BWIDTH   = 8,
    parameter int                RD_MODE  = 0,
    parameter int                OREG     = 0,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    output logic                       busy,
    input  logic                       re,
    input  logic                       we,
    input  logic [DWIDTH/BWIDTH-1:0]   be,
    input  logic [AWIDTH-1:0]          addr,
    input  logic [DWIDTH-1:0]          din,
    output logic [DWIDTH-1:0]          dout,
    output logic                       dvalid
);
    localparam int NBYTE  = DWIDTH / BWIDTH;
    localparam int DEPTH  = 2**AWIDTH;
    localparam int STAGES = OREG;
    localparam int VW     = STAGES + 1;

    generate
        if (DWIDTH % BWIDTH != 0) begin : g_bad_width
            $error("ldl_ram_p1_be: DWIDTH (%0d) must be a multiple of BWIDTH (%0d)", DWIDTH, BWIDTH);
        end
        if (RD_MODE < 0 || RD_MODE > 2) begin : g_bad_mode
            $error("ldl_ram_p1_be: RD_MODE (%0d) must be 0, 1 or 2", RD_MODE);
        end
        if (OREG < 0 || OREG > 1) begin : g_bad_oreg
            $error("ldl_ram_p1_be: OREG (%0d) must be 0 or 1", OREG);
        end
    endgenerate

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [AWIDTH-1:0] cnt;
    logic              busy_q;
    logic              sweep;
    logic              rd;

    // Clear sequencer: one word per cycle, leaves on the cycle that writes
    // the last address; cnt wraps back to 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AWIDTH'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (clr) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign sweep = (state == CLEAR);

    // No-change mode drops the read entirely when a write shares the cycle.
    assign rd = re && !sweep && !(RD_MODE == 2 && we);

    logic [NBYTE-1:0][BWIDTH-1:0] lane_q;

    generate
        for (genvar i = 0; i < NBYTE; i++) begin : g_lane
            ldl_ram_p1_be_lane #(
                .AWIDTH (AWIDTH),
                .BWIDTH (BWIDTH),
                .RD_MODE(RD_MODE)
            ) u_lane (
                .clk  (clk),
                .rst_n(rst_n),
                .wen  (sweep || (we && be[i])),
                .ren  (rd),
                .addr (sweep ? cnt : addr),
                .wdata(sweep ? INIT_VAL[i*BWIDTH +: BWIDTH] : din[i*BWIDTH +: BWIDTH]),
                .rdata(lane_q[i])
            );
        end
    endgenerate

    // vld_pipe[0] tracks the lane read register, vld_pipe[STAGES] is dvalid.
    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= VW'({vld_pipe, rd});
    end

    assign dvalid = vld_pipe[STAGES];

    generate
        if (OREG == 1) begin : g_oreg
            logic [DWIDTH-1:0] dq;
            // Only advance on valid data so dout holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           dq <= '0;
                else if (vld_pipe[0]) dq <= lane_q;
            end
            assign dout = dq;
        end else begin : g_noreg
            assign dout = lane_q;
        end
    endgenerate
endmodule

// File: tb/tb_ldl_ram_p1_be.sv
module tb_ldl_ram_p1_be;
    localparam int DW = 16, AW = 4, BW = 8, DEPTH = 16, NI = 3;
    localparam logic [15:0] INIT = 16'hA5A5;

    // Instance k: RD_MODE = k; instance 1 also has the output register.
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, re = 1'b0, we = 1'b0;
    logic [1:0]  be = '0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout [NI];
    logic        dvalid [NI];
    logic        busy [NI];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            ldl_ram_p1_be #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .RD_MODE(k),
                            .OREG(k == 1 ? 1 : 0), .INIT_VAL(INIT)) u_dut (
                .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy[k]),
                .re(re), .we(we), .be(be), .addr(addr), .din(din),
                .dout(dout[k]), .dvalid(dvalid[k]));
        end
    endgenerate

    // Reference model: word array, remaining sweep cycles, and per instance a
    // queue of reads tagged with the cycle their data is due on dout.
    typedef struct { int due; logic [15:0] d; } ent_t;
    logic [15:0] mmem [DEPTH];
    ent_t        q [NI][$];
    logic [15:0] edout [NI];
    logic        edv [NI];
    int clr_left, cyc;
    int checks = 0, passes = 0;

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] d, logic [1:0] b);
        logic [15:0] r = old;
        if (b[0]) r[7:0]  = d[7:0];
        if (b[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic model_reset();
        clr_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) mmem[a] = INIT;
        for (int k = 0; k < NI; k++) begin
            q[k].delete();
            edout[k] = '0;
            edv[k] = 1'b0;
        end
    endtask

    task automatic apply(logic c, logic r, logic w, logic [1:0] b, logic [3:0] a, logic [15:0] d);
        clr = c; re = r; we = w; be = b; addr = a; din = d;
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (clr_left > 0) clr_left--;
            else begin
                for (int k = 0; k < NI; k++)
                    if (re && !(k == 2 && we)) begin
                        e.due = cyc + (k == 1 ? 1 : 0);
                        e.d   = (k == 1 && we) ? merge(mmem[addr], din, be) : mmem[addr];
                        q[k].push_back(e);
                    end
                if (we) mmem[addr] = merge(mmem[addr], din, be);
                if (clr) begin
                    clr_left = DEPTH;
                    for (int a = 0; a < DEPTH; a++) mmem[a] = INIT;
                end
            end
            for (int k = 0; k < NI; k++) begin
                edv[k] = 1'b0;
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    edv[k] = 1'b1;
                    edout[k] = q[k][0].d;
                    void'(q[k].pop_front());
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n [NI];
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (busy[k] !== 1'b1 || dout[k] !== 16'h0 || dvalid[k] !== 1'b0)
                $display("FAIL reset_state inst%0d: busy=%b dout=%h dvalid=%b want busy=1 dout=0000 dvalid=0",
                         k, busy[k], dout[k], dvalid[k]);
            else passes++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) n[k] = busy[k] ? 1 : 0;
        for (int t = 0; t < 40 && (busy[0] || busy[1] || busy[2]); t++) begin
            tick();
            for (int k = 0; k < NI; k++) if (busy[k] === 1'b1) n[k]++;
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (n[k] !== DEPTH)
                $display("FAIL reset_busy_len inst%0d: busy cycles=%0d want %0d", k, n[k], DEPTH);
            else passes++;
        end
    endtask

    task automatic test_clear_contents();
        for (int s = 0; s < DEPTH + 2; s++) begin
            if (s < DEPTH) apply(0, 1, 0, 2'b00, 4'(s), 16'h0);
            else           apply(0, 0, 0, 2'b00, 4'h0, 16'h0);
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dout[k] !== edout[k] || dvalid[k] !== edv[k] || busy[k] !== 1'b0)
                    $display("FAIL clear_read inst%0d step%0d: dout=%h dvalid=%b busy=%b want dout=%h dvalid=%b busy=0",
                             k, s, dout[k], dvalid[k], busy[k], edout[k], edv[k]);
                else passes++;
            end
        end
    endtask

    task automatic test_byte_enables();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: apply(0, 0, 1, 2'b11, 4'd3, 16'h1234);
                1: apply(0, 0, 1, 2'b10, 4'd3, 16'hABCD);
                2: apply(0, 1, 0, 2'b00, 4'd3, 16'h0);
                default: apply(0, 0, 0, 2'b00, 4'd0, 16'h0);
            endcase
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dout[k] !== edout[k] || dvalid[k] !== edv[k])
                    $display("FAIL byte_en inst%0d step%0d: dout=%h dvalid=%b want dout=%h dvalid=%b",
                             k, s, dout[k], dvalid[k], edout[k], edv[k]);
                else passes++;
            end
            if (s == 2 || s == 3) begin
                checks++;
                if (dout[s-2] !== 16'hAB34 || dvalid[s-2] !== 1'b1)
                    $display("FAIL byte_en_const inst%0d: dout=%h dvalid=%b want dout=ab34 dvalid=1",
                             s - 2, dout[s-2], dvalid[s-2]);
                else passes++;
            end
        end
    endtask

    task automatic test_rdw();
        logic [15:0] held;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: apply(0, 0, 1, 2'b11, 4'd5, 16'h0001);
                1: apply(0, 1, 1, 2'b11, 4'd5, 16'h00FF);
                2: apply(0, 1, 0, 2'b00, 4'd5, 16'h0);
                default: apply(0, 0, 0, 2'b00, 4'd0, 16'h0);
            endcase
            held = dout[2];
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dout[k] !== edout[k] || dvalid[k] !== edv[k])
                    $display("FAIL rdw inst%0d step%0d: dout=%h dvalid=%b want dout=%h dvalid=%b",
                             k, s, dout[k], dvalid[k], edout[k], edv[k]);
                else passes++;
            end
            if (s == 1) begin
                checks++;
                if (dout[0] !== 16'h0001 || dvalid[0] !== 1'b1)
                    $display("FAIL rdw_read_first: dout=%h dvalid=%b want dout=0001 dvalid=1", dout[0], dvalid[0]);
                else passes++;
                checks++;
                if (dout[2] !== held || dvalid[2] !== 1'b0)
                    $display("FAIL rdw_no_change: dout=%h dvalid=%b want dout=%h dvalid=0", dout[2], dvalid[2], held);
                else passes++;
            end
            if (s == 2) begin
                checks++;
                if (dout[1] !== 16'h00FF || dout[0] !== 16'h00FF || dout[2] !== 16'h00FF)
                    $display("FAIL rdw_followup: dout0=%h dout1=%h dout2=%h want 00ff each", dout[0], dout[1], dout[2]);
                else passes++;
            end
        end
    endtask

    task automatic test_busy_access();
        int t;
        apply(1, 0, 0, 2'b00, 4'd0, 16'h0);
        tick();
        apply(0, 1, 1, 2'b11, 4'd2, 16'hFFFF);
        for (t = 0; t < 40 && busy[0] === 1'b1; t++) begin
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dvalid[k] !== edv[k] || dout[k] !== edout[k] || busy[k] !== 1'b1)
                    $display("FAIL busy_ignore inst%0d cyc%0d: dout=%h dvalid=%b busy=%b want dout=%h dvalid=%b busy=1",
                             k, t, dout[k], dvalid[k], busy[k], edout[k], edv[k]);
                else passes++;
            end
            tick();
        end
        checks++;
        if (t !== DEPTH) $display("FAIL busy_len: busy cycles=%0d want %0d", t, DEPTH);
        else passes++;
        apply(0, 1, 0, 2'b00, 4'd2, 16'h0);
        tick();
        apply(0, 0, 0, 2'b00, 4'd0, 16'h0);
        checks++;
        if (dout[0] !== INIT || dvalid[0] !== 1'b1 || dout[2] !== INIT)
            $display("FAIL busy_after_read: dout0=%h dout2=%h dvalid0=%b want %h %h 1", dout[0], dout[2], dvalid[0], INIT, INIT);
        else passes++;
        tick();
        checks++;
        if (dout[1] !== INIT || dvalid[1] !== 1'b1)
            $display("FAIL busy_after_read_oreg: dout=%h dvalid=%b want %h 1", dout[1], dvalid[1], INIT);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        for (int s = 0; s < 11; s++) begin
            if (s < 4)      apply(0, 0, 1, 2'b11, 4'(s), 16'(s));
            else if (s < 8) apply(0, 1, 0, 2'b00, 4'(s - 4), 16'h0);
            else            apply(0, 0, 0, 2'b00, 4'd0, 16'h0);
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dout[k] !== edout[k] || dvalid[k] !== edv[k])
                    $display("FAIL b2b inst%0d step%0d: dout=%h dvalid=%b want dout=%h dvalid=%b",
                             k, s, dout[k], dvalid[k], edout[k], edv[k]);
                else passes++;
            end
            // First re is driven in step 4; data due two cycles later.
            if (dvalid[1] === 1'b1) nv++;
            if (s >= 5 && s <= 8) begin
                checks++;
                if (dvalid[1] !== 1'b1 || dout[1] !== 16'(s - 5))
                    $display("FAIL b2b_oreg step%0d: dout=%h dvalid=%b want dout=%h dvalid=1", s, dout[1], dvalid[1], 16'(s - 5));
                else passes++;
            end
        end
        checks++;
        if (nv !== 4) $display("FAIL b2b_count: dvalid cycles=%0d want 4", nv);
        else passes++;
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        apply(1, 0, 0, 2'b00, 4'd0, 16'h0);
        tick();
        apply(0, 0, 0, 2'b00, 4'd0, 16'h0);
        repeat (7) tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (busy[k] !== 1'b1 || dout[k] !== 16'h0 || dvalid[k] !== 1'b0)
                $display("FAIL midreset_state inst%0d: busy=%b dout=%h dvalid=%b want 1 0000 0", k, busy[k], dout[k], dvalid[k]);
            else passes++;
        end
        rst_n = 1'b1;
        n = busy[0] ? 1 : 0;
        for (int t = 0; t < 40 && busy[0] === 1'b1; t++) begin
            tick();
            if (busy[0] === 1'b1) n++;
        end
        checks++;
        if (n !== DEPTH) $display("FAIL midreset_busy_len: busy cycles=%0d want %0d", n, DEPTH);
        else passes++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            apply($urandom_range(63) == 0, $urandom_range(1), $urandom_range(1),
                  2'($urandom_range(3)), 4'($urandom_range(15)), 16'($urandom));
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dout[k] !== edout[k] || dvalid[k] !== edv[k] || busy[k] !== (clr_left > 0))
                    $display("FAIL random inst%0d step%0d: dout=%h dvalid=%b busy=%b want dout=%h dvalid=%b busy=%b",
                             k, s, dout[k], dvalid[k], busy[k], edout[k], edv[k], clr_left > 0);
                else passes++;
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_clear_contents();
        test_byte_enables();
        test_rdw();
        test_busy_access();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ldl_ram_p1_be.md
# ldl_ram_p1_be

Parametrised single-port synchronous RAM, the successor to the basic 1-port RAM. Adds per-byte write enables and a selectable read-during-write mode. An optional output pipeline register and a hardware clear sequencer sweep every word to a known value after reset or on request. It is the general-purpose on-chip storage primitive for buffers, lookup tables and context stores.

## Interface
- DWIDTH, 32, data word width; must be a multiple of BWIDTH
- AWIDTH, 6, address width; DEPTH = 2**AWIDTH words
- BWIDTH, 8, bits per byte lane; NBYTE = DWIDTH/BWIDTH
- RD_MODE, 0, read-during-write mode: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change (read suppressed)
- OREG, 0, 1 adds one output register stage
- INIT_VAL, 0, DWIDTH-bit value written to every word by the clear sequencer

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  request a full-memory clear; sampled only in IDLE
- busy  out  1  high while the clear sweep runs; accesses are ignored
- re  in  1  read enable
- we  in  1  write enable
- be  in  NBYTE  byte-lane write enables; lane i covers din[i*BWIDTH +: BWIDTH]
- addr  in  AWIDTH  word address for the read and/or write
- din  in  DWIDTH  write data
- dout  out  DWIDTH  read data, held between reads
- dvalid  out  1  one-cycle pulse marking new data on dout

## Operation
- FSM has two states: CLEAR and IDLE. Reset forces CLEAR with the sweep counter at 0.
- CLEAR:
  - each cycle write INIT_VAL (all lanes) to mem[cnt], then cnt += 1.
  - On the cycle that writes cnt = DEPTH-1, move to IDLE. cnt wraps to 0.
  - busy = 1 throughout CLEAR. re, we and clr are ignored, and no dvalid is generated.
- IDLE:
  - busy = 0. clr = 1 moves to CLEAR next cycle, with cnt = 0. Any re/we in the same cycle as clr is still executed.
  - we = 1: for each lane with be[i] = 1, write that lane of din to mem[addr]. Lanes with be[i] = 0 keep their contents. we = 1 with be = 0 writes nothing.
  - re = 1: read mem[addr].
- re = 1 and we = 1 in the same cycle (same addr by construction):
  - RD_MODE 0: returned data = pre-write word.
  - RD_MODE 1: returned data = post-write word (written lanes from din, other lanes old).
  - RD_MODE 2: read suppressed; dout holds its value and no dvalid is generated.
- Memory array has no reset. Contents are defined only after the first CLEAR completes; in simulation the array starts as X.
- Asserting rst_n low mid-sweep or mid-access aborts the operation. The sweep restarts from address 0 after release; in-flight reads are dropped.
- Illegal parameter combinations (DWIDTH % BWIDTH != 0, RD_MODE > 2) trigger an elaboration-time $error.

## Timing
- Reset values: busy = 1, dout = 0, dvalid = 0, internal pipeline regs = 0, cnt = 0.
- Clear duration: busy stays high for exactly DEPTH cycles after the first rising edge with rst_n high, then drops. The first access is accepted on the cycle busy = 0.
- clr sampled at edge N in IDLE: busy = 1 from N+1 through N+DEPTH; IDLE again at N+DEPTH+1.
- Read latency (re sampled at edge N):
  - OREG = 0: dout/dvalid update at edge N+1.
  - OREG = 1: dout/dvalid update at edge N+2.
  - Fully pipelined, one read per cycle.
- Write latency: data written at edge N is visible to a read sampled at edge N+1 in all modes.
- dvalid is high for exactly one cycle per accepted read. dout changes only alongside dvalid, or on reset.

## Test plan
- Reset/clear (DWIDTH=16, AWIDTH=4, INIT_VAL=16'hA5A5):
  - release rst_n -> busy high for exactly 16 cycles.
  - reads of addr 0..15 then return 16'hA5A5; dvalid pulses 1 (OREG=0) or 2 (OREG=1) cycles after each re.
- Byte enables:
  - write 16'h1234 with be=2'b11 to addr 3, then 16'hABCD with be=2'b10 -> read addr 3 returns 16'hAB34.
- Read-during-write (addr 5 holds 16'h0001; re=we=1, din=16'h00FF, be=2'b11):
  - RD_MODE 0 -> dout = 16'h0001.
  - RD_MODE 1 -> dout = 16'h00FF.
  - RD_MODE 2 -> dout holds, no dvalid.
  - A subsequent read in all modes -> 16'h00FF.
- Access during busy:
  - pulse clr, then issue we to addr 2 with din=16'hFFFF during the sweep -> ignored; no dvalid.
  - After busy drops, addr 2 reads INIT_VAL.
- Back-to-back reads with OREG=1:
  - re on 4 consecutive cycles to addr 0..3 holding 0,1,2,3 -> dout = 0,1,2,3 on 4 consecutive cycles starting 2 cycles after the first re; dvalid high for exactly 4 cycles.
- Reset mid-sweep:
  - assert rst_n low at cnt=7 for 1 cycle -> busy stays high; full 16-cycle sweep restarts from addr 0; dout = 0 and dvalid = 0 during reset.
